// File: rtl/bpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// bpsk_tx_ctrl : BPSK frame sequencer - one +sin sync symbol, then MSB-first data
// Rev 1.0
// ============================================================================
module bpsk_tx_ctrl #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int DATA_WIDTH    = 12
) (
  input  logic                             clk,
  input  logic                             arst,
  input  logic                             en,
  input  logic                             s_valid,
  input  logic [DATA_WIDTH-1:0]            s_data,
  output logic                             s_ready,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] sample_addr,
  output logic                             phase_sel,
  output logic                             mod_en,
  output logic                             busy,
  output logic                             done
);

  localparam int c_addr_w = $clog2(SAMPLE_NUMBER);
  localparam int c_bit_w  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [c_addr_w-1:0] c_last_sample = c_addr_w'(SAMPLE_NUMBER - 1);
  localparam logic [c_bit_w-1:0]  c_last_bit    = c_bit_w'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_addr_w-1:0]     cnt_q, cnt_d;
  logic [c_bit_w-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    phase_sel_q, phase_sel_d;
  logic                    busy_q, busy_d;
  logic                    s_ready_q, s_ready_d;

  logic                    w_sym_end;

  assign w_sym_end = en && (cnt_q == c_last_sample);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;

    case (state_q)
      ST_IDLE: begin
        if (en && s_valid) begin
          shreg_d = s_data;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_SYNC;
        end
      end

      ST_SYNC: begin
        if (en) begin
          // Counter width is exactly log2(SAMPLE_NUMBER), so it wraps on its own
          cnt_d = cnt_q + 1'b1;
          if (w_sym_end) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (en) begin
          cnt_d = cnt_q + 1'b1;
          if (w_sym_end) begin
            if (bit_q == c_last_bit) begin
              bit_d   = '0;
              shreg_d = '0;
              state_d = ST_IDLE;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = shreg_q << 1;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
        shreg_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the registers
  always_comb begin
    busy_d      = (state_d != ST_IDLE);
    s_ready_d   = (state_d == ST_IDLE);
    phase_sel_d = 1'b0;
    case (state_d)
      ST_SYNC: phase_sel_d = 1'b1;
      ST_DATA: phase_sel_d = shreg_d[DATA_WIDTH-1];
      default: phase_sel_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      phase_sel_q <= 1'b0;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      phase_sel_q <= phase_sel_d;
      busy_q      <= busy_d;
      s_ready_q   <= s_ready_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign busy        = busy_q;
  assign phase_sel   = phase_sel_q;
  assign sample_addr = cnt_q;
  assign mod_en      = busy_q && en;
  assign done        = (state_q == ST_DATA) && w_sym_end && (bit_q == c_last_bit);

endmodule
`default_nettype wire

// File: tb/tb_bpsk_tx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bpsk_tx_ctrl : directed bench with cycle model and symbol scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_bpsk_tx_ctrl;

  localparam int SN    = 256;
  localparam int DW    = 12;
  localparam int AW    = $clog2(SN);
  localparam int FRAME = (DW + 1) * SN;

  logic          clk = 1'b0;
  logic          arst;
  logic          en;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] sample_addr;
  logic          phase_sel;
  logic          mod_en;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  bpsk_tx_ctrl #(.SAMPLE_NUMBER(SN), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .arst        (arst),
    .en          (en),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .sample_addr (sample_addr),
    .phase_sel   (phase_sel),
    .mod_en      (mod_en),
    .busy        (busy),
    .done        (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: frame position as (symbol index, sample index); symbol 0 is sync
  bit            m_busy     = 1'b0;
  int            m_cnt      = 0;
  int            m_sym      = 0;
  logic [DW-1:0] m_word     = '0;
  int            cyc        = 0;
  int            hs_cyc     = -1;
  int            hs_count   = 0;
  int            done_cyc   = -1;
  int            done_count = 0;
  bit            exp_q[$];

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_busy = 1'b0;
      m_cnt  = 0;
      m_sym  = 0;
      exp_q.delete();
    end else if (en) begin
      if (!m_busy) begin
        if (s_valid) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_sym  = 0;
          m_word = s_data;
          hs_cyc = cyc;
          hs_count++;
          exp_q.push_back(1'b1);
          for (int i = DW - 1; i >= 0; i--) exp_q.push_back(s_data[i]);
        end
      end else if (m_cnt == SN - 1) begin
        m_cnt = 0;
        if (m_sym == DW) m_busy = 1'b0;
        else             m_sym++;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic exp_phase;
    logic exp_done;
    bit   sb_bit;
    cyc++;
    exp_phase = !m_busy ? 1'b0 : ((m_sym == 0) ? 1'b1 : m_word[DW - m_sym]);
    exp_done  = m_busy && en && (m_sym == DW) && (m_cnt == SN - 1);
    check("s_ready", s_ready, !m_busy);
    check("busy", busy, m_busy);
    check("sample_addr", sample_addr, m_busy ? m_cnt : 0);
    check("phase_sel", phase_sel, exp_phase);
    check("mod_en", mod_en, m_busy && en);
    check("done", done, exp_done);
    if (done) begin
      done_cyc = cyc;
      done_count++;
    end
    if (mod_en && (sample_addr == AW'(SN - 1))) begin
      check("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        sb_bit = exp_q.pop_front();
        check("sb_symbol_phase", phase_sel, sb_bit);
      end
    end
  end

  task automatic wait_done(input int maxc, input string tag);
    int  start;
    bit  found;
    start = done_count;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (done_count != start) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_hs(input int target, input int maxc, input string tag);
    bit found;
    found = (hs_count >= target);
    for (int i = 0; i < maxc && !found; i++) begin
      @(posedge clk); #1;
      if (hs_count >= target) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  task automatic wait_pos(input int sym, input int cnt, input int maxc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (m_busy && m_sym == sym && m_cnt == cnt) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int d1;

    arst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_addr", sample_addr, 0);
    check("rst_done", done, 0);

    // Word presented in the same step arst falls: accepted on the very next edge
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0; en = 1'b1; s_valid = 1'b1; s_data = 12'hA5C;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 12'h3C3;
    check("first_hs_after_rst", hs_count, 1);
    check("busy_after_hs", busy, 1);
    wait_done(FRAME + 10, "nominal_done_seen");
    check("nominal_frame_len", done_cyc - hs_cyc, FRAME);
    @(posedge clk); #1;
    check("nominal_sb_drained", exp_q.size(), 0);

    // Handshake gating with en low
    en = 1'b0; s_valid = 1'b1; s_data = 12'h5A6;
    repeat (5) begin
      @(posedge clk); #1;
      check("gate_no_accept", busy, 0);
    end
    hs0 = hs_count;
    en = 1'b1;
    @(posedge clk); #1;
    check("gate_accept", hs_count, hs0 + 1);
    s_valid = 1'b0;

    // Ten-cycle stall at sample 100 of data bit 3
    wait_pos(4, 100, 2 * FRAME, "stall_point_seen");
    en = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_addr", sample_addr, 100);
      check("stall_mod_en", mod_en, 0);
    end
    en = 1'b1;
    wait_done(FRAME + 20, "stall_done_seen");
    check("stall_frame_len", done_cyc - hs_cyc, FRAME + 10);

    // Back-to-back frames with s_valid held high
    @(posedge clk); #1;
    hs0 = hs_count;
    s_valid = 1'b1; s_data = 12'hFFF;
    wait_hs(hs0 + 1, 10, "b2b_first_hs");
    s_data = 12'h000;
    wait_done(FRAME + 10, "b2b_first_done");
    d1 = done_cyc;
    wait_hs(hs0 + 2, 10, "b2b_second_hs");
    check("b2b_gap", hs_cyc, d1 + 1);
    s_valid = 1'b0;
    wait_done(FRAME + 10, "b2b_second_done");
    @(posedge clk); #1;
    check("b2b_sb_drained", exp_q.size(), 0);

    // Asynchronous reset at sample 50 of data bit 6
    hs0 = hs_count;
    s_valid = 1'b1; s_data = 12'h6B1;
    wait_hs(hs0 + 1, 10, "rst_frame_hs");
    s_valid = 1'b0;
    wait_pos(7, 50, FRAME, "rst_point_seen");
    #2 arst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_s_ready", s_ready, 1);
    check("arst_addr", sample_addr, 0);
    check("arst_phase", phase_sel, 0);
    check("arst_mod_en", mod_en, 0);
    check("arst_done", done, 0);
    repeat (3) @(posedge clk);
    #1 arst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("no_resume_busy", busy, 0);
    check("rst_sb_flushed", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bpsk_tx_ctrl.md
BPSK_TX_CTRL -- requirements
Module: bpsk_tx_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256: carrier samples per symbol, a power of two, at least 4.
REQ-002 SHALL have parameter DATA_WIDTH, default 12: bits per transmitted word.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port arst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: advance enable; low freezes all state.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream word valid.
REQ-007 SHALL have port s_data, input, DATA_WIDTH bits: word to transmit.
REQ-008 SHALL have port s_ready, output, 1 bit: the block accepts a word.
REQ-009 SHALL have port sample_addr, output, log2(SAMPLE_NUMBER) bits: sine LUT index.
REQ-010 SHALL have port phase_sel, output, 1 bit: 1 selects +sin, 0 selects -sin.
REQ-011 SHALL have port mod_en, output, 1 bit: modulator output valid this cycle.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM states IDLE, SYNC and DATA, all registered.
REQ-015 IDLE: s_ready=1, busy=0, mod_en=0, sample_addr=0, phase_sel=0.
REQ-016 Handshake: a word is accepted on a rising edge with s_valid=1, s_ready=1 and en=1; s_data is latched into a shift register and the FSM moves to SYNC with the sample counter at 0.
REQ-017 s_valid while en=0 SHALL NOT be accepted; s_data SHALL be ignored when no handshake occurs.
REQ-018 SYNC: transmits exactly one symbol with phase_sel=1 (sync bit); busy=1, s_ready=0, mod_en=en.
REQ-019 DATA: transmits DATA_WIDTH symbols MSB first; phase_sel = current shift-register MSB.
REQ-020 Sample counter: increments by 1 each cycle with en=1 in SYNC or DATA; sample_addr equals the counter.
REQ-021 Symbol end: at counter = SAMPLE_NUMBER-1 with en=1, the counter wraps to 0, and in DATA the shift register shifts left by 1.
REQ-022 DATA SHALL use a bit counter 0..DATA_WIDTH-1; at the end of symbol DATA_WIDTH-1 the FSM returns to IDLE.
REQ-023 Frame end: done=1 for exactly that final cycle, combinational with the final counter value.
REQ-024 Frame length: (DATA_WIDTH+1)*SAMPLE_NUMBER enabled cycles from the cycle after the handshake.
REQ-025 en=0 mid-frame: counters, shift register, state and phase_sel hold; mod_en=0, done=0; resume with no lost or repeated sample.
REQ-026 Back-to-back: a new word can be accepted the cycle after return to IDLE, giving exactly one idle cycle between frames.
REQ-027 s_valid held during a frame SHALL NOT corrupt the frame; that word is accepted on the first IDLE cycle.

Reset
REQ-028 arst=1 SHALL immediately force IDLE, clear both counters and the shift register, and drive sample_addr=0, phase_sel=0, mod_en=0, busy=0, done=0, s_ready=1.
REQ-029 No handshake SHALL occur while arst=1.
REQ-030 Reset mid-frame SHALL discard the word; the frame SHALL NOT resume after release.
REQ-031 The first handshake SHALL be possible on the first rising edge after arst falls.

Verification
REQ-032 Nominal: SAMPLE_NUMBER=256, DATA_WIDTH=12, en=1, word 0xA5C -> 256 cycles phase_sel=1, then bits 1,0,1,0,0,1,0,1,1,1,0,0 of 256 cycles each; done pulse at cycle 3328; sample_addr ramps 0..255 every symbol.
REQ-033 Stall: en=0 for 10 cycles at sample_addr=100 in bit 3 -> sample_addr stays 100, mod_en=0 for those cycles; done is delayed by exactly 10 cycles.
REQ-034 Back-to-back: s_valid held high with words 0xFFF then 0x000 -> second handshake on the cycle after the done cycle; second frame is sync 1 followed by twelve 0 symbols.
REQ-035 Reset mid-frame: arst pulsed at sample 50 of bit 6 -> outputs reach reset values without waiting for clk; after release, busy=0 until a new handshake.
REQ-036 Handshake gating: s_valid=1 with en=0 for 5 cycles -> no acceptance, busy=0; acceptance on the first cycle with en=1.
